// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider (div_iter / div_step).
//   - div_state_e : controller states IDLE / BUSY / DONE
//   - DIV_WIDTH   : operand and result width (32)
//   - DIV_ITERS   : restoring iterations per operation, one quotient bit each
//   - DIV_CNT_W   : iteration counter width; CNT_LAST is its final value
//   - abs33 / dvd_mag / div_result : operand magnitude and result fix-up helpers
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = 5;
  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // 33-bit magnitude so that -2^31 has a representable absolute value.
  function automatic logic [DIV_WIDTH:0] abs33(input logic [DIV_WIDTH-1:0] v,
                                               input logic               sgn);
    return (sgn && v[DIV_WIDTH-1]) ? -{1'b1, v} : {1'b0, v};
  endfunction

  // Dividend magnitude never exceeds 2^32-1, so the low 32 bits are exact.
  function automatic logic [DIV_WIDTH-1:0] dvd_mag(input logic [DIV_WIDTH-1:0] v,
                                                   input logic               sgn);
    logic [DIV_WIDTH:0] m;
    m = abs33(v, sgn);
    return m[DIV_WIDTH-1:0];
  endfunction

  // Final result selection. Divide-by-zero ignores the magnitude datapath:
  // quotient is all ones and remainder is the untouched original dividend.
  function automatic logic [DIV_WIDTH-1:0] div_result(
    input logic                 is_mod,
    input logic                 zero,
    input logic                 neg_q,
    input logic                 neg_r,
    input logic [DIV_WIDTH-1:0] quo,
    input logic [DIV_WIDTH-1:0] rem,
    input logic [DIV_WIDTH-1:0] dvd
  );
    if (zero)   return is_mod ? dvd : '1;
    if (is_mod) return neg_r ? -rem : rem;
    return neg_q ? -quo : quo;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   rem      : current partial remainder (always < divisor, so 32 bits suffice)
//   divisor  : 33-bit divisor magnitude
//   in_bit   : next dividend bit shifted into the partial remainder
//   rem_next : partial remainder after the trial subtraction / restore
//   q_bit    : quotient bit produced by this iteration
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem,
  input  logic [DIV_WIDTH:0]   divisor,
  input  logic                 in_bit,
  output logic [DIV_WIDTH-1:0] rem_next,
  output logic                 q_bit
);

  logic [DIV_WIDTH:0] shifted;

  assign shifted = {rem, in_bit};
  assign q_bit   = (shifted >= divisor);
  // The true difference is below the divisor, so a 32-bit subtract is exact.
  assign rem_next = q_bit ? (shifted[DIV_WIDTH-1:0] - divisor[DIV_WIDTH-1:0])
                          : shifted[DIV_WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit integer divider (signed/unsigned, quotient or remainder).
// Restoring radix-2: one quotient bit per BUSY cycle, result 32 edges after
// the accepting edge, held in DONE until the consumer takes it.
//   clk, resetn          : clock, asynchronous active-low reset
//   div_valid/div_ready  : request handshake (ready only in IDLE)
//   div_signed           : 1 = signed operation, 0 = unsigned
//   div_is_mod           : 1 = return remainder, 0 = return quotient
//   div_dividend/divisor : operands
//   div_cancel           : flush, returns to IDLE from any state
//   res_valid/res_ready  : result handshake
//   res_data             : registered result, zero while res_valid is low
// Build option: DIV_ZERO_FAST_EN skips the BUSY iterations for a zero divisor
// (result one edge after acceptance); result values are the same either way.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic             div_is_mod,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  input  logic             div_cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
);

  div_state_e           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DIV_WIDTH-1:0] rem_q;      // partial remainder
  logic [DIV_WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
  logic [DIV_WIDTH:0]   dvsr_q;     // divisor magnitude
  logic [DIV_WIDTH-1:0] dvd_q;      // original dividend (divide-by-zero remainder)
  logic                 neg_q;
  logic                 neg_r;
  logic                 is_mod;
  logic                 dvsr_zero;

  logic [DIV_WIDTH-1:0] step_rem;
  logic                 step_q;
  logic [DIV_WIDTH-1:0] result;
  logic                 zero_in;

  div_step u_step (
    .rem      (rem_q),
    .divisor  (dvsr_q),
    .in_bit   (quo_q[DIV_WIDTH-1]),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Valid on the last BUSY cycle (step outputs complete the quotient) and
  // for the zero-divisor case, where the override ignores the datapath.
  assign result = div_result(is_mod, dvsr_zero, neg_q, neg_r,
                             {quo_q[DIV_WIDTH-2:0], step_q}, step_rem, dvd_q);

  assign zero_in   = (div_divisor == '0);
  assign div_ready = (state == IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      dvd_q     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      is_mod    <= 1'b0;
      dvsr_zero <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (div_cancel) begin
      // Flush wins over every handshake, including a coincident request.
      state     <= IDLE;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid) begin
            rem_q     <= '0;
            quo_q     <= dvd_mag(div_dividend, div_signed);
            dvsr_q    <= abs33(div_divisor, div_signed);
            dvd_q     <= div_dividend;
            neg_q     <= div_signed & (div_dividend[DIV_WIDTH-1] ^ div_divisor[DIV_WIDTH-1]);
            neg_r     <= div_signed & div_dividend[DIV_WIDTH-1];
            is_mod    <= div_is_mod;
            dvsr_zero <= zero_in;
            cnt       <= '0;
`ifdef DIV_ZERO_FAST_EN
            state     <= zero_in ? DONE : BUSY;
`else
            state     <= BUSY;
`endif
          end
        end
        BUSY: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[DIV_WIDTH-2:0], step_q};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= result;
          end
        end
        DONE: begin
          if (!res_valid) begin
            // Zero-divisor fast path enters DONE with the result not yet out.
            res_valid <= 1'b1;
            res_data  <= result;
          end else if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: scoreboard of expected results pushed at
// request time and popped when res_valid rises.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic        div_signed = 1'b0;
  logic        div_is_mod = 1'b0;
  logic [31:0] div_dividend = '0;
  logic [31:0] div_divisor = '0;
  logic        div_cancel = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;

  int n_checks = 0;
  int n_fail = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 32;
`endif

  typedef struct {
    logic [31:0] data;
    int          lat;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  div_iter #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_signed   (div_signed),
    .div_is_mod   (div_is_mod),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_cancel   (div_cancel),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Drive one request, push its expectation, return #1 after the accept edge.
  task automatic issue(input string name, input logic sgn, input logic mod,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_data, input int lat);
    exp_t e;
    @(negedge clk);
    div_signed = sgn; div_is_mod = mod; div_dividend = a; div_divisor = b;
    div_valid = 1'b1;
    e.data = exp_data; e.lat = lat; e.name = name;
    exp_q.push_back(e);
    n_checks++;
    if (div_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: div_ready=%b required 1", name, div_ready);
    end
    @(posedge clk); #1;
    div_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (res_valid !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // Scoreboard pop: latency and data of the oldest outstanding request.
  task automatic sb_pop_compare();
    exp_t e;
    int   edges;
    e = exp_q.pop_front();
    wait_valid(edges);
    n_checks++;
    if (edges != e.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges required %0d", e.name, edges, e.lat);
    end
    n_checks++;
    if (res_data !== e.data) begin
      n_fail++;
      $display("FAIL %s data: got %h required %h", e.name, res_data, e.data);
    end
  endtask

  // Complete op with res_ready high; checks the result is released next edge.
  task automatic run_op(input string name, input logic sgn, input logic mod,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_data, input int lat);
    issue(name, sgn, mod, a, b, exp_data, lat);
    sb_pop_compare();
    @(posedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0 || div_ready !== 1'b1 || res_data !== 32'h0) begin
      n_fail++;
      $display("FAIL %s release: valid=%b ready=%b data=%h required 0/1/0",
               name, res_valid, div_ready, res_data);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (div_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h required 1/0/0",
               div_ready, res_valid, res_data);
    end
    #2 resetn = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] a, b;
    run_op("u_100div7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32);
    run_op("u_100mod7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32);
    run_op("u_max_div1", 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32);
    run_op("u_small_big", 1'b0, 1'b1, 32'd3, 32'hFFFFFFFF, 32'd3, 32);
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = (i == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (b == 0) b = 1;
      run_op("u_rand_div", 1'b0, 1'b0, a, b, a / b, 32);
      run_op("u_rand_mod", 1'b0, 1'b1, a, b, a % b, 32);
    end
  endtask

  task automatic test_signed();
    int sa, sb;
    run_op("s_m7div2", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32);
    run_op("s_m7mod2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32);
    run_op("s_min_div_m1", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32);
    run_op("s_min_mod_m1", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32);
    run_op("s_7div_m2", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32);
    run_op("s_7mod_m2", 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32);
    for (int i = 0; i < 3; i++) begin
      sa = int'($urandom);
      sb = int'($urandom_range(0, 2000)) - 1000;
      if (sb == 0) sb = -3;
      run_op("s_rand_div", 1'b1, 1'b0, sa, sb, sa / sb, 32);
      run_op("s_rand_mod", 1'b1, 1'b1, sa, sb, sa % sb, 32);
    end
  endtask

  task automatic test_div_zero();
    run_op("z_u_div", 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, ZERO_LAT);
    run_op("z_u_mod", 1'b0, 1'b1, 32'd5, 32'd0, 32'd5, ZERO_LAT);
    run_op("z_s_div", 1'b1, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, ZERO_LAT);
    run_op("z_s_mod_neg", 1'b1, 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, ZERO_LAT);
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    res_ready = 1'b0;
    issue("bp_op", 1'b0, 1'b0, 32'd1000, 32'd9, 32'd111, 32);
    sb_pop_compare();
    held = res_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      div_valid = 1'b1; div_dividend = 32'd77; div_divisor = 32'd7;
      @(posedge clk); #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== held || div_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid=%b data=%h ready=%b required 1/%h/0",
                 i, res_valid, res_data, div_ready, held);
      end
    end
    @(negedge clk);
    div_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0 || div_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b required 0/1", res_valid, div_ready);
    end
    run_op("b2b_op", 1'b0, 1'b1, 32'd1000, 32'd9, 32'd1, 32);
  endtask

  task automatic test_cancel();
    logic seen;
    int   edges;
    // Cancel mid-operation.
    issue("cx_busy", 1'b0, 1'b0, 32'd500, 32'd3, 32'd166, 32);
    exp_q.delete(exp_q.size() - 1);
    repeat (9) @(posedge clk);
    @(negedge clk); div_cancel = 1'b1;
    @(posedge clk); #1; div_cancel = 1'b0;
    n_checks++;
    if (div_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cx_busy_idle: ready=%b valid=%b required 1/0", div_ready, res_valid);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (res_valid === 1'b1) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL cx_busy_noresult: res_valid seen=%b required 0", seen);
    end
    // Cancel coincident with a request in IDLE: no acceptance.
    @(negedge clk);
    div_valid = 1'b1; div_cancel = 1'b1; div_dividend = 32'd9; div_divisor = 32'd0;
    @(posedge clk); #1;
    div_valid = 1'b0; div_cancel = 1'b0;
    n_checks++;
    if (div_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cx_idle_noaccept: ready=%b required 1", div_ready);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (res_valid === 1'b1) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL cx_idle_noresult: res_valid seen=%b required 0", seen);
    end
    // Cancel coincident with the result handshake.
    res_ready = 1'b0;
    issue("cx_done", 1'b0, 1'b0, 32'd64, 32'd8, 32'd8, 32);
    sb_pop_compare();
    @(negedge clk); res_ready = 1'b1; div_cancel = 1'b1;
    @(posedge clk); #1; div_cancel = 1'b0;
    n_checks++;
    if (div_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'h0) begin
      n_fail++;
      $display("FAIL cx_done_idle: ready=%b valid=%b data=%h required 1/0/0",
               div_ready, res_valid, res_data);
    end
    wait_valid(edges);
    n_checks++;
    if (edges != 100) begin
      n_fail++;
      $display("FAIL cx_done_noresult: res_valid after %0d edges required none", edges);
    end
  endtask

  task automatic test_reset_abort();
    // Reset during BUSY: outputs go to reset values with no clock edge.
    issue("rst_busy", 1'b0, 1'b0, 32'h12345678, 32'h11, 32'h0, 32);
    exp_q.delete(exp_q.size() - 1);
    repeat (20) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (div_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_busy_async: ready=%b valid=%b data=%h required 1/0/0",
               div_ready, res_valid, res_data);
    end
    @(negedge clk); resetn = 1'b1;
    // Reset while a result is held.
    res_ready = 1'b0;
    issue("rst_done", 1'b0, 1'b0, 32'd90, 32'd9, 32'd10, 32);
    sb_pop_compare();
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (div_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_done_async: ready=%b valid=%b data=%h required 1/0/0",
               div_ready, res_valid, res_data);
    end
    @(negedge clk); resetn = 1'b1; res_ready = 1'b1;
    run_op("post_rst", 1'b0, 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_cancel();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
